uart_mmio_bridge: RTL and testbench



---
 rtl/uart_mmio_bridge.sv | 233 +++++++++++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped front end for the RS-232 receiver/transmitter.
// Bus window: addr 0 = DATA (read pops RX FIFO, write pushes TX FIFO),
//             addr 1 = STATUS {overrun, rx_not_empty, tx_not_full}.
// The RX FIFO is filled from the receiver ready/clear handshake; the TX FIFO is
// drained by an IDLE/START/WAIT FSM that spaces start pulses on tx_busy.
// Optional build macro: UART_OVERRUN_FLAG_EN adds a sticky RX overrun flag at
// STATUS bit2, cleared by a STATUS read. Without it, bit2 reads 0.
module uart_mmio_bridge #(
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic        bus_addr,
    input  logic [7:0]  bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    input  logic        rx_ready,
    input  logic [7:0]  rx_data,
    output logic        rx_clear,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0] RX_FULL = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0] TX_FULL = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT
    } txState_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic dataRead;
    logic dataWrite;
    logic statusRead;

    assign dataRead   = bus_req && !bus_we && !bus_addr;
    assign dataWrite  = bus_req &&  bus_we && !bus_addr;
    assign statusRead = bus_req && !bus_we &&  bus_addr;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       rxMem [RX_DEPTH];
    logic [RX_AW-1:0] rxWrPtr;
    logic [RX_AW-1:0] rxRdPtr;
    logic [RX_AW:0]   rxCount;
    logic             rxNotEmpty;
    logic             rxCapture;
    logic             rxPop;
    logic             rxPush;

    // A byte is captured only while no clear is outstanding; rx_ready stays
    // high for one more cycle after rx_clear, which this masks.
    assign rxNotEmpty = (rxCount != '0);
    assign rxCapture  = rx_ready && !rx_clear;
    assign rxPop      = dataRead && rxNotEmpty;
    assign rxPush     = rxCapture && ((rxCount < RX_FULL) || rxPop);

    // RX pointers and occupancy; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            if (rxPush) rxWrPtr <= rxWrPtr + 1'b1;
            if (rxPop)  rxRdPtr <= rxRdPtr + 1'b1;
            case ({rxPush, rxPop})
                2'b10:   rxCount <= rxCount + 1'b1;
                2'b01:   rxCount <= rxCount - 1'b1;
                default: ;
            endcase
        end
    end

    // RX storage array.
    // NOTE: memory is not reset; occupancy is tracked by the reset pointers/count, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (rxPush) rxMem[rxWrPtr] <= rx_data;
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]       txMem [TX_DEPTH];
    logic [TX_AW-1:0] txWrPtr;
    logic [TX_AW-1:0] txRdPtr;
    logic [TX_AW:0]   txCount;
    logic             txNotEmpty;
    logic             txNotFull;
    logic             txPop;
    logic             txPush;

    assign txNotEmpty = (txCount != '0);
    assign txNotFull  = (txCount < TX_FULL);
    assign txPush     = dataWrite && (txNotFull || txPop);

    // TX pointers and occupancy; writes to a full FIFO without a same-cycle pop are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txWrPtr <= '0;
            txRdPtr <= '0;
            txCount <= '0;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + 1'b1;
            if (txPop)  txRdPtr <= txRdPtr + 1'b1;
            case ({txPush, txPop})
                2'b10:   txCount <= txCount + 1'b1;
                2'b01:   txCount <= txCount - 1'b1;
                default: ;
            endcase
        end
    end

    // TX storage array.
    always_ff @(posedge clk) begin
        if (txPush) txMem[txWrPtr] <= bus_wdata;
    end

    // ------------------------------------------------------------------
    // Optional sticky overrun flag
    // ------------------------------------------------------------------
    logic overrunBit;

`ifdef UART_OVERRUN_FLAG_EN
    logic rxDrop;
    logic overrun;

    assign rxDrop     = rxCapture && !rxPush;
    assign overrunBit = overrun;

    // Set on a dropped RX byte, cleared by a STATUS read; a drop wins over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= (overrun && !statusRead) || rxDrop;
        end
    end
`else
    assign overrunBit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus response
    // ------------------------------------------------------------------
    logic [31:0] busRdataNext;

    // Read mux on the pre-access FIFO state; writes and empty DATA reads return 0.
    always_comb begin
        // NOTE: default assigned first so every path drives the signal and no latch is inferred.
        busRdataNext = '0;
        if (dataRead && rxNotEmpty) begin
            busRdataNext = {24'd0, rxMem[rxRdPtr]};
        end else if (statusRead) begin
            busRdataNext = {29'd0, overrunBit, rxNotEmpty, txNotFull};
        end
    end

    // Registered bus response and the one-cycle receiver clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            rx_clear  <= 1'b0;
        end else begin
            bus_ack   <= bus_req;
            bus_rdata <= busRdataNext;
            rx_clear  <= rxCapture;
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    txState_e   txState;
    txState_e   txStateNext;
    logic       txStartNext;
    logic [7:0] txDataNext;

    // State, start pulse and held transmit byte registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txState  <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            txState  <= txStateNext;
            tx_start <= txStartNext;
            tx_data  <= txDataNext;
        end
    end

    // Launch only from IDLE with an idle transmitter, so a transmitter that
    // survived a reset can never be restarted while still shifting.
    always_comb begin
        txStateNext = txState;
        txStartNext = 1'b0;
        txDataNext  = tx_data;
        txPop       = 1'b0;
        unique case (txState)
            TX_IDLE: begin
                if (txNotEmpty && !tx_busy) begin
                    txPop       = 1'b1;
                    txStartNext = 1'b1;
                    txDataNext  = txMem[txRdPtr];
                    txStateNext = TX_START;
                end
            end
            TX_START: begin
                txStateNext = TX_WAIT;
            end
            TX_WAIT: begin
                if (!tx_busy) txStateNext = TX_IDLE;
            end
            default: begin
                txStateNext = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Self-checking bench for uart_mmio_bridge: queue-based reference model of
// both FIFOs, the bus window and the receiver handshake, compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
`timescale 1ns/1ps
module tb_uart_mmio_bridge;

    localparam int RXD = 16;
    localparam int TXD = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_req = 1'b0;
    logic        bus_we = 1'b0;
    logic        bus_addr = 1'b0;
    logic [7:0]  bus_wdata = '0;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_clear;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;

    uart_mmio_bridge #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_clear(rx_clear),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model ----------------
    logic holdBusy = 1'b0;
    logic randBusy = 1'b0;
    int   busyCnt  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) busyCnt = randBusy ? int'($urandom_range(1, 12)) : 10;
            else if (busyCnt > 0) busyCnt--;
            tx_busy = holdBusy || (busyCnt > 0);
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  sentLog[$];
    logic        mOvf = 1'b0;
    logic        expClear = 1'b0;
    logic        prevStart = 1'b0;
    logic [7:0]  mTxData = '0;
    int          stallCnt = 0;
    int          startCount = 0;
    int          clearCount = 0;

    logic        sRstn = 1'b0, sReq = 1'b0, sWe = 1'b0, sAddr = 1'b0;
    logic        sRxReady = 1'b0, sBusy = 1'b0;
    logic [7:0]  sWdata = '0, sRxData = '0;

    logic        mPopRx, mStatusRd, mCapture, mDrop, mPopped;
    int          mTxBefore;
    logic [31:0] mExpRd;

    // Inputs as seen by the DUT at the active edge.
    always @(posedge clk) begin
        sRstn = rst_n; sReq = bus_req; sWe = bus_we; sAddr = bus_addr; sWdata = bus_wdata;
        sRxReady = rx_ready; sRxData = rx_data; sBusy = tx_busy;
    end

    // Apply the edge just taken to the model, then compare all DUT outputs.
    always @(negedge clk) begin
        if (!rst_n || !sRstn) begin
            rxq.delete(); txq.delete();
            mOvf = 1'b0; expClear = 1'b0; prevStart = 1'b0; mTxData = '0; stallCnt = 0;
            check("reset_outputs", {27'd0, bus_ack, rx_clear, tx_start, (bus_rdata != 0), (tx_data != 0)}, 32'd0);
        end else begin
            check("bus_ack", {31'd0, bus_ack}, {31'd0, sReq});
            mPopRx = 1'b0;
            mStatusRd = 1'b0;
            if (sReq && !sWe) begin
                if (!sAddr) begin
                    mExpRd = (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0;
                    mPopRx = (rxq.size() > 0);
                end else begin
                    mExpRd = {29'd0, mOvf, rxq.size() != 0, txq.size() < TXD};
                    mStatusRd = 1'b1;
                end
                check("bus_rdata", bus_rdata, mExpRd);
            end
            if (mPopRx) void'(rxq.pop_front());
            mCapture = sRxReady && !expClear;
            mDrop = 1'b0;
            if (mCapture) begin
                if (rxq.size() < RXD) rxq.push_back(sRxData);
                else mDrop = 1'b1;
            end
`ifdef UART_OVERRUN_FLAG_EN
            mOvf = (mOvf && !mStatusRd) || mDrop;
`endif
            expClear = mCapture;
            check("rx_clear", {31'd0, rx_clear}, {31'd0, expClear});
            if (rx_clear) clearCount++;

            mTxBefore = txq.size();
            mPopped = tx_start && !prevStart;
            check("tx_start_width", {31'd0, tx_start && prevStart}, 32'd0);
            if (mPopped) begin
                check("tx_pop_nonempty", {31'd0, mTxBefore > 0}, 32'd1);
                check("tx_start_while_busy", {31'd0, sBusy}, 32'd0);
                if (mTxBefore > 0) begin
                    mTxData = txq.pop_front();
                    sentLog.push_back(mTxData);
                end
                startCount++;
            end
            check("tx_data", {24'd0, tx_data}, {24'd0, mTxData});
            if (sReq && sWe && !sAddr && (mTxBefore < TXD || mPopped)) txq.push_back(sWdata);
            prevStart = tx_start;

            if (txq.size() > 0 && !sBusy && !tx_start) stallCnt++;
            else stallCnt = 0;
            check("tx_progress", {31'd0, stallCnt < 6}, 32'd1);
        end
    end

    // ---------------- stimulus helpers (entered at a falling edge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic addr, input logic [7:0] d);
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = d;
        @(negedge clk);
        bus_req = 1'b0; bus_we = 1'b0;
    endtask

    task automatic busRead(input logic addr, output logic [31:0] d);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_wdata = 8'($urandom);
        @(negedge clk);
        d = bus_rdata;
        bus_req = 1'b0;
    endtask

    task automatic rxSend(input logic [7:0] b);
        int n = 0;
        rx_ready = 1'b1; rx_data = b;
        do begin
            @(negedge clk);
            n++;
        end while (!rx_clear && n < 20);
        check("rx_handshake", {31'd0, rx_clear}, 32'd1);
        rx_ready = 1'b0;
    endtask

    task automatic waitTxDrain(input int maxCycles);
        int n = 0;
        while ((txq.size() != 0 || tx_busy || tx_start) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        check("tx_drain_in_time", {31'd0, n < maxCycles}, 32'd1);
        idle(3);
    endtask

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    logic [31:0] rd;
    int s0, c0, n;

    initial begin
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);

        // Reset state and STATUS after reset.
        check("post_reset_tx_start", {31'd0, tx_start}, 32'd0);
        check("post_reset_rx_clear", {31'd0, rx_clear}, 32'd0);
        busRead(1'b1, rd);
        check("status_after_reset", rd, 32'h1);
        check("ack_with_status", {31'd0, bus_ack}, 32'd1);
        idle(2);

        // Two back-to-back TX writes with a 10-cycle transmitter.
        s0 = startCount;
        busWrite(1'b0, 8'h55);
        busWrite(1'b0, 8'hA3);
        waitTxDrain(100);
        check("tx_two_starts", startCount - s0, 32'd2);
        if (sentLog.size() >= 2) begin
            check("tx_first_byte", {24'd0, sentLog[sentLog.size() - 2]}, 32'h55);
            check("tx_second_byte", {24'd0, sentLog[sentLog.size() - 1]}, 32'hA3);
        end

        // Single RX byte.
        c0 = clearCount;
        rxSend(8'h3C);
        idle(2);
        check("rx_single_clear", clearCount - c0, 32'd1);
        busRead(1'b1, rd); check("status_rx_pending", rd, 32'h3);
        busRead(1'b0, rd); check("data_3c", rd, 32'h3C);
        busRead(1'b1, rd); check("status_rx_drained", rd, 32'h1);

        // RX overflow: 17 bytes into a 16-deep FIFO.
        c0 = clearCount;
        for (int i = 0; i < 17; i++) rxSend(8'(i));
        idle(2);
        check("rx_17_clears", clearCount - c0, 32'd17);
        busRead(1'b1, rd);
`ifdef UART_OVERRUN_FLAG_EN
        check("status_overrun", rd, 32'h7);
`else
        check("status_full_rx", rd, 32'h3);
`endif
        for (int i = 0; i < 17; i++) begin
            busRead(1'b0, rd);
            check("rx_drain_data", rd, (i < 16) ? 32'(i) : 32'd0);
        end
        busRead(1'b1, rd); check("status_after_rx_drain", rd, 32'h1);

        // TX overflow with the transmitter held busy.
        holdBusy = 1'b1;
        idle(2);
        s0 = startCount;
        for (int i = 0; i < 17; i++) busWrite(1'b0, 8'h80 + 8'(i));
        busRead(1'b1, rd); check("status_tx_full", rd, 32'h0);
        holdBusy = 1'b0;
        waitTxDrain(400);
        check("tx_16_starts", startCount - s0, 32'd16);
        if (sentLog.size() > 0) check("tx_last_kept_byte", {24'd0, sentLog[sentLog.size() - 1]}, 32'h8F);

        // Reset while the FSM waits on the transmitter with 3 bytes queued.
        s0 = startCount;
        for (int i = 0; i < 4; i++) busWrite(1'b0, 8'hC1 + 8'(i));
        n = 0;
        while (startCount == s0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_started", {31'd0, startCount > s0}, 32'd1);
        idle(3);
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = 1'b1;
        @(posedge clk);
        #2;
        check("ack_before_reset", {31'd0, bus_ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {20'd0, bus_ack, rx_clear, tx_start, (bus_rdata != 0), tx_data}, 32'd0);
        bus_req = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        s0 = startCount;
        idle(15);
        check("no_start_after_reset", startCount - s0, 32'd0);
        busRead(1'b1, rd); check("status_after_mid_reset", rd, 32'h1);

        // Randomized traffic on both directions.
        randBusy = 1'b1;
        fork
            begin
                repeat (1500) begin
                    @(negedge clk);
                    bus_req   = ($urandom_range(0, 99) < 60);
                    bus_we    = 1'($urandom_range(0, 1));
                    bus_addr  = ($urandom_range(0, 3) == 0);
                    bus_wdata = 8'($urandom);
                end
                @(negedge clk);
                bus_req = 1'b0;
            end
            begin
                repeat (150) begin
                    rxSend(8'($urandom));
                    idle(int'($urandom_range(0, 8)));
                end
            end
        join
        waitTxDrain(2000);
        n = 0;
        while (rxq.size() > 0 && n < 40) begin
            busRead(1'b0, rd);
            n++;
        end
        check("rx_model_drained", rxq.size(), 32'd0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
